// File: rtl/fd.sv
// Integer clock divider: clk_out runs at f(clk)/DIVISOR with 50 % duty.
// Odd divisors add a falling-edge helper flop to stretch the high phase by half a cycle.
`timescale 1ns/1ps
module fd #(
  parameter int DIVISOR = 2,
  parameter int WIDTH   = 8
) (
  input  logic clk,
  input  logic rst,
  output logic clk_out
);

  localparam logic [WIDTH-1:0] LAST   = WIDTH'(DIVISOR - 1);
  localparam logic [WIDTH-1:0] THRESH = (DIVISOR % 2 == 0) ? WIDTH'(DIVISOR / 2)
                                                           : WIDTH'((DIVISOR - 1) / 2);

  if (DIVISOR < 2 || DIVISOR > (2 ** WIDTH) - 1) begin : g_bad_divisor
    $error("fd: DIVISOR must lie in 2..2**WIDTH-1");
  end

  logic [WIDTH-1:0] cnt;
  logic             p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      p   <= 1'b0;
    end else begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      p   <= (cnt < THRESH);
    end
  end

  if (DIVISOR % 2 == 0) begin : g_even
    assign clk_out = p;
  end else begin : g_odd
    // n lags p by half a cycle, so the OR covers p's fall without a low pulse.
    logic n;

    always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
        n <= 1'b0;
      end else begin
        n <= p;
      end
    end

    assign clk_out = p | n;
  end

endmodule

// File: tb/tb_fd.sv
// Self-checking bench for fd: four instances (DIVISOR 2, 3, 4, 5) share one clock and reset.
// Expected waveforms come from a half-cycle index: clk_out is high for the first DIVISOR halves of every 2*DIVISOR.
`timescale 1ns/1ps
module tb_fd;

  logic clk;
  logic rst;
  logic co2, co3, co4, co5;

  int checkCount = 0;
  int passCount  = 0;

  logic   measureOn = 1'b0;
  longint last3 = -1;
  longint last5 = -1;

  fd dut2 (.clk(clk), .rst(rst), .clk_out(co2));
  fd #(.DIVISOR(3)) dut3 (.clk(clk), .rst(rst), .clk_out(co3));
  fd #(.DIVISOR(4)) dut4 (.clk(clk), .rst(rst), .clk_out(co4));
  fd #(.DIVISOR(5)) dut5 (.clk(clk), .rst(rst), .clk_out(co5));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, actual, expected);
    end
  endtask

  function automatic logic expClk(input int j, input int d);
    return (j % (2 * d)) < d;
  endfunction

  function automatic int expCnt(input int j, input int d);
    return (j / 2 + 1) % d;
  endfunction

  // Sample j lies just after the j-th half-cycle boundary counted from the first active edge.
  task automatic applyStimulus(input int nSamples);
    for (int j = 0; j < nSamples; j++) begin
      checkOutput("d2 clk_out", co2, expClk(j, 2));
      checkOutput("d3 clk_out", co3, expClk(j, 3));
      checkOutput("d4 clk_out", co4, expClk(j, 4));
      checkOutput("d5 clk_out", co5, expClk(j, 5));
      checkOutput("d2 cnt", dut2.cnt, expCnt(j, 2));
      checkOutput("d5 cnt", dut5.cnt, expCnt(j, 5));
      #5;
    end
  endtask

  task automatic checkAllLow(input string tag);
    checkOutput({tag, " d2"}, co2, 0);
    checkOutput({tag, " d3"}, co3, 0);
    checkOutput({tag, " d4"}, co4, 0);
    checkOutput({tag, " d5"}, co5, 0);
    checkOutput({tag, " d2 cnt"}, dut2.cnt, 0);
    checkOutput({tag, " d5 cnt"}, dut5.cnt, 0);
  endtask

  // Any glitch or wrong duty shows up as a phase of the wrong length.
  always @(co3) begin
    if (measureOn) begin
      if (last3 >= 0) checkOutput("d3 phase len", longint'($time) - last3, 15);
      last3 = longint'($time);
    end
  end

  always @(co5) begin
    if (measureOn) begin
      if (last5 >= 0) checkOutput("d5 phase len", longint'($time) - last5, 25);
      last5 = longint'($time);
    end
  end

  initial begin
    rst = 1'b0;
    #2  checkAllLow("reset t2");
    #5  checkAllLow("reset t7");
    #5  checkAllLow("reset t12");
    #1  rst = 1'b1;
    #4  applyStimulus(44);

    checkOutput("d2 high before reset", co2, 1);
    checkOutput("d3 high before reset", co3, 1);
    #1  rst = 1'b0;
    #1  checkAllLow("async assert");

    #3;
    for (int i = 0; i < 40; i++) begin
      checkAllLow("reset hold");
      #5;
    end

    #1;
    last3 = -1;
    last5 = -1;
    measureOn = 1'b1;
    rst = 1'b1;
    #4  applyStimulus(1100);
    measureOn = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
